// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer sharing one synchronous-read RAM.
// Each transaction runs IDLE -> ACC -> (RDW) -> DONE, with a one-cycle ack in DONE.
module mem_arbiter #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_req,
    input  logic [2:0]    r0_cmd,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_ack,
    input  logic          r1_req,
    input  logic [2:0]    r1_cmd,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_ack,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_wr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy,
    output logic          gnt_id
);

    localparam logic [2:0] MREAD  = 3'b010;
    localparam logic [2:0] MWRITE = 3'b100;

    typedef enum logic [1:0] {IDLE, ACC, RDW, DONE} state_t;

    state_t        r_state;
    logic          r_is_wr;
    logic          r_last_grant;
    logic          r_gnt_id;
    logic          r_busy;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_ram_wr;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_wdata;
    logic [DW-1:0] r_rdata;

    logic          w_v0;
    logic          w_v1;
    logic          w_pick1;
    logic          w_sel_wr;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    // Only exact one-hot read/write commands count; MNONE and malformed codes are ignored.
    assign w_v0 = r0_req && ((r0_cmd == MREAD) || (r0_cmd == MWRITE));
    assign w_v1 = r1_req && ((r1_cmd == MREAD) || (r1_cmd == MWRITE));

    // On a tie the port that did not win last time is chosen.
    assign w_pick1     = w_v1 && (!w_v0 || !r_last_grant);
    assign w_sel_wr    = w_pick1 ? (r1_cmd == MWRITE) : (r0_cmd == MWRITE);
    assign w_sel_addr  = w_pick1 ? r1_addr  : r0_addr;
    assign w_sel_wdata = w_pick1 ? r1_wdata : r0_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_gnt_id     <= 1'b0;
            r_busy       <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_ram_wr     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_rdata      <= '0;
        end else begin
            r_ram_wr <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_v0 || w_v1) begin
                        r_gnt_id   <= w_pick1;
                        r_is_wr    <= w_sel_wr;
                        r_ram_addr <= w_sel_addr;
                        r_busy     <= 1'b1;
                        r_state    <= ACC;
                        // Strobe and data are loaded here so they appear during ACC.
                        if (w_sel_wr) begin
                            r_ram_wr    <= 1'b1;
                            r_ram_wdata <= w_sel_wdata;
                        end
                    end
                end
                ACC: begin
                    if (r_is_wr) begin
                        r_ack0  <= ~r_gnt_id;
                        r_ack1  <= r_gnt_id;
                        r_state <= DONE;
                    end else begin
                        r_state <= RDW;
                    end
                end
                RDW: begin
                    r_rdata <= ram_rdata;
                    r_ack0  <= ~r_gnt_id;
                    r_ack1  <= r_gnt_id;
                    r_state <= DONE;
                end
                DONE: begin
                    r_last_grant <= r_gnt_id;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign r0_ack    = r_ack0;
    assign r1_ack    = r_ack1;
    assign rdata     = r_rdata;
    assign ram_addr  = r_ram_addr;
    assign ram_wr    = r_ram_wr;
    assign ram_wdata = r_ram_wdata;
    assign busy      = r_busy;
    assign gnt_id    = r_gnt_id;

endmodule
